// File: rtl/branch_predict_resolve_unit.sv
// Branch resolve unit with a 2-bit-counter BHT predictor.
// Resolve results are registered; prediction reads the table combinationally.
module branch_predict_resolve_unit #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned BHT_DEPTH = 16,
  parameter logic [1:0]  BHT_INIT  = 2'b01
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [XLEN-1:0] PRED_PC,
  output logic            PRED_TAKEN,
  input  logic            RES_VALID,
  input  logic [XLEN-1:0] RES_PC,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  input  logic [3:0]      SELECT,
  input  logic            RES_PRED_TAKEN,
  output logic            OUT_VALID,
  output logic            BJ_SIG,
  output logic            MISPREDICT,
  output logic [31:0]     BRANCH_COUNT,
  output logic [31:0]     MISPRED_COUNT
);

  localparam int unsigned IW = $clog2(BHT_DEPTH);

  logic [1:0]    r_bht [BHT_DEPTH];
  logic          r_out_valid;
  logic          r_bj;
  logic          r_mis;
  logic [31:0]   r_bcnt;
  logic [31:0]   r_mcnt;

  logic [IW-1:0] w_pidx;
  logic [IW-1:0] w_ridx;
  logic          w_is_br;
  logic          w_is_cond;
  logic          w_take;
  logic          w_bj;
  logic          w_mis;
  logic          w_eq;
  logic          w_lt;
  logic          w_ltu;

  assign w_pidx     = PRED_PC[IW+1:2];
  assign w_ridx     = RES_PC[IW+1:2];
  assign PRED_TAKEN = r_bht[w_pidx][1];

  assign w_eq  = (DATA1 == DATA2);
  assign w_lt  = ($signed(DATA1) < $signed(DATA2));
  assign w_ltu = (DATA1 < DATA2);

  always_comb begin
    w_is_br   = 1'b1;
    w_is_cond = 1'b1;
    w_take    = 1'b0;
    case (SELECT)
      4'b1010: begin
        w_is_cond = 1'b0;
        w_take    = 1'b1;
      end
      4'b1000: w_take = w_eq;
      4'b1001: w_take = ~w_eq;
      4'b1100: w_take = w_lt;
      4'b1101: w_take = ~w_lt;
      4'b1110: w_take = w_ltu;
      4'b1111: w_take = ~w_ltu;
      default: begin
        w_is_br   = 1'b0;
        w_is_cond = 1'b0;
      end
    endcase
  end

  assign w_bj  = w_is_br & w_take;
  assign w_mis = w_is_br & (w_take != RES_PRED_TAKEN);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        r_bht[i] <= BHT_INIT;
      end
      r_out_valid <= 1'b0;
      r_bj        <= 1'b0;
      r_mis       <= 1'b0;
      r_bcnt      <= '0;
      r_mcnt      <= '0;
    end else begin
      r_out_valid <= RES_VALID;
      r_bj        <= RES_VALID & w_bj;
      r_mis       <= RES_VALID & w_mis;
      if (RES_VALID && w_is_br && (r_bcnt != '1)) begin
        r_bcnt <= r_bcnt + 32'd1;
      end
      if (RES_VALID && w_mis && (r_mcnt != '1)) begin
        r_mcnt <= r_mcnt + 32'd1;
      end
      // Jumps never train the table; only conditional branches do.
      if (RES_VALID && w_is_cond) begin
        if (w_take && (r_bht[w_ridx] != 2'b11)) begin
          r_bht[w_ridx] <= r_bht[w_ridx] + 2'd1;
        end else if (!w_take && (r_bht[w_ridx] != 2'b00)) begin
          r_bht[w_ridx] <= r_bht[w_ridx] - 2'd1;
        end
      end
    end
  end

  assign OUT_VALID     = r_out_valid;
  assign BJ_SIG        = r_bj;
  assign MISPREDICT    = r_mis;
  assign BRANCH_COUNT  = r_bcnt;
  assign MISPRED_COUNT = r_mcnt;

endmodule

// File: tb/tb_branch_predict_resolve_unit.sv
// Scoreboard bench for branch_predict_resolve_unit.
// Directed resolves push expectations; a negedge monitor pops and compares.
module tb_branch_predict_resolve_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] PRED_PC;
  logic        PRED_TAKEN;
  logic        RES_VALID;
  logic [31:0] RES_PC;
  logic [31:0] DATA1;
  logic [31:0] DATA2;
  logic [3:0]  SELECT;
  logic        RES_PRED_TAKEN;
  logic        OUT_VALID;
  logic        BJ_SIG;
  logic        MISPREDICT;
  logic [31:0] BRANCH_COUNT;
  logic [31:0] MISPRED_COUNT;

  typedef struct packed {
    logic        bj;
    logic        mis;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  branch_predict_resolve_unit #(
    .XLEN(32), .BHT_DEPTH(16), .BHT_INIT(2'b01)
  ) dut (
    .CLK(CLK), .RESET(RESET), .PRED_PC(PRED_PC),
    .PRED_TAKEN(PRED_TAKEN), .RES_VALID(RES_VALID),
    .RES_PC(RES_PC), .DATA1(DATA1), .DATA2(DATA2),
    .SELECT(SELECT), .RES_PRED_TAKEN(RES_PRED_TAKEN),
    .OUT_VALID(OUT_VALID), .BJ_SIG(BJ_SIG),
    .MISPREDICT(MISPREDICT), .BRANCH_COUNT(BRANCH_COUNT),
    .MISPRED_COUNT(MISPRED_COUNT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (OUT_VALID === 1'b1) begin
      exp_t e;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: OUT_VALID with empty scoreboard");
      end else begin
        e = q.pop_front();
        if ({BJ_SIG, MISPREDICT, BRANCH_COUNT, MISPRED_COUNT} !== e) begin
          errors++;
          $display("FAIL resolve: got bj=%b mis=%b bc=%0d mc=%0d expected bj=%b mis=%b bc=%0d mc=%0d",
                   BJ_SIG, MISPREDICT, BRANCH_COUNT, MISPRED_COUNT,
                   e.bj, e.mis, e.bc, e.mc);
        end
      end
    end
  end

  task automatic step(input logic rst, input logic vld,
                      input logic [3:0] sel, input logic [31:0] pc,
                      input logic [31:0] d1, input logic [31:0] d2,
                      input logic rpt, input logic [31:0] ppc,
                      input logic pchk, input logic epred,
                      input logic ebj, input logic emis,
                      input logic [31:0] ebc, input logic [31:0] emc);
    exp_t e;
    @(negedge CLK);
    RESET = rst; RES_VALID = vld; SELECT = sel; RES_PC = pc;
    DATA1 = d1; DATA2 = d2; RES_PRED_TAKEN = rpt; PRED_PC = ppc;
    if (vld && !rst) begin
      e = '{bj: ebj, mis: emis, bc: ebc, mc: emc};
      q.push_back(e);
    end
    #1;
    if (pchk) chk("pred_taken", {31'd0, PRED_TAKEN}, {31'd0, epred});
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_out_valid"}, {31'd0, OUT_VALID}, 32'd0);
    chk({nm, "_bj"}, {31'd0, BJ_SIG}, 32'd0);
    chk({nm, "_mis"}, {31'd0, MISPREDICT}, 32'd0);
  endtask

  initial begin
    RESET = 1'b1; RES_VALID = 1'b0; SELECT = 4'h0; RES_PC = '0;
    DATA1 = '0; DATA2 = '0; RES_PRED_TAKEN = 1'b0; PRED_PC = 32'h40;
    repeat (2) step(1, 0, 4'h0, 0, 0, 0, 0, 32'h40, 0, 0, 0, 0, 0, 0);
    step(0, 0, 4'h0, 0, 0, 0, 0, 32'h40, 1, 0, 0, 0, 0, 0);
    chk_idle("reset");
    chk("reset_bcnt", BRANCH_COUNT, 32'd0);
    chk("reset_mcnt", MISPRED_COUNT, 32'd0);

    // signed vs unsigned compare on -1 vs 1
    step(0, 1, 4'hC, 32'h104, 32'hFFFFFFFF, 1, 0, 32'h40, 0, 0, 1, 1, 1, 1);
    step(0, 1, 4'hE, 32'h104, 32'hFFFFFFFF, 1, 0, 32'h40, 0, 0, 0, 0, 2, 1);
    // train index 0 up to saturation; 0x80 aliases 0x40
    step(0, 1, 4'h8, 32'h40, 214, 214, 0, 32'h40, 1, 0, 1, 1, 3, 2);
    step(0, 1, 4'h8, 32'h40, 214, 214, 0, 32'h80, 1, 1, 1, 1, 4, 3);
    step(0, 1, 4'h8, 32'h40, 214, 214, 0, 32'h40, 1, 1, 1, 1, 5, 4);
    step(0, 1, 4'h9, 32'h40, 214, 214, 1, 32'h40, 1, 1, 0, 1, 6, 5);
    step(0, 1, 4'h9, 32'h40, 214, 214, 1, 32'h40, 1, 1, 0, 1, 7, 6);
    // jump and non-branch codes leave the table alone
    step(0, 1, 4'hA, 32'h40, 1, 2, 1, 32'h40, 1, 0, 1, 0, 8, 6);
    step(0, 1, 4'h3, 32'h40, 5, 5, 1, 32'h40, 1, 0, 0, 0, 8, 6);
    step(0, 1, 4'hB, 32'h40, 5, 5, 1, 32'h40, 1, 0, 0, 0, 8, 6);
    step(0, 1, 4'hD, 32'h108, 32'hFFFFFFFF, 1, 0, 32'h40, 1, 0, 0, 0, 9, 6);
    step(0, 1, 4'hF, 32'h108, 32'hFFFFFFFF, 1, 0, 32'h40, 1, 0, 1, 1, 10, 7);
    step(0, 0, 4'h8, 32'h40, 0, 0, 0, 32'h40, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    chk_idle("idle");
    chk("idle_bcnt", BRANCH_COUNT, 32'd10);

    step(0, 1, 4'h8, 32'h40, 7, 7, 1, 32'h40, 1, 0, 1, 0, 11, 7);
    step(0, 1, 4'h8, 32'h40, 7, 7, 1, 32'h40, 1, 1, 1, 0, 12, 7);
    // reset beats a same-cycle taken BNE
    step(1, 1, 4'h9, 32'h40, 1, 2, 0, 32'h40, 1, 1, 0, 0, 0, 0);
    step(0, 0, 4'h0, 32'h40, 0, 0, 0, 32'h40, 1, 0, 0, 0, 0, 0);
    chk_idle("rst_res");
    chk("rst_res_bcnt", BRANCH_COUNT, 32'd0);
    chk("rst_res_mcnt", MISPRED_COUNT, 32'd0);

    repeat (3) @(negedge CLK);
    chk("scoreboard_empty", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predict_resolve_unit.md
BRANCH_PREDICT_RESOLVE_UNIT -- requirements
Module: branch_predict_resolve_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand and PC width.
REQ-002 SHALL have parameter BHT_DEPTH, default 16, meaning BHT entry count; power of 2, at least 2.
REQ-003 SHALL have parameter BHT_INIT, default 2'b01, meaning per-entry counter value after reset.
REQ-004 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port RESET, input, 1, synchronous active-high reset.
REQ-006 SHALL have port PRED_PC, input, XLEN, fetch PC to predict.
REQ-007 SHALL have port PRED_TAKEN, output, 1, combinational prediction for PRED_PC.
REQ-008 SHALL have port RES_VALID, input, 1, resolve request valid this cycle.
REQ-009 SHALL have port RES_PC, input, XLEN, PC of the branch being resolved.
REQ-010 SHALL have ports DATA1 and DATA2, input, XLEN each, compare operands.
REQ-011 SHALL have port SELECT, input, 4, branch/jump op code.
REQ-012 SHALL have port RES_PRED_TAKEN, input, 1, prediction previously made for RES_PC.
REQ-013 SHALL have port OUT_VALID, output, 1, registered; resolve result valid.
REQ-014 SHALL have port BJ_SIG, output, 1, registered; branch/jump taken.
REQ-015 SHALL have port MISPREDICT, output, 1, registered; actual outcome differs from RES_PRED_TAKEN.
REQ-016 SHALL have ports BRANCH_COUNT and MISPRED_COUNT, output, 32 each, registered statistics.

Function
REQ-017 SHALL index the BHT with PC[log2(BHT_DEPTH)+1:2] for both PRED_PC and RES_PC.
REQ-018 SHALL drive PRED_TAKEN = bit 1 of the indexed 2-bit counter, read from the current (pre-edge) table state.
REQ-019 SHALL decode SELECT as follows: 1010 JAL/JALR, always taken; 1000 BEQ; 1001 BNE; 1100 BLT, signed; 1101 BGE, signed; 1110 BLTU, unsigned; 1111 BGEU, unsigned.
REQ-020 SHALL treat any SELECT with bit 3 = 0, and code 1011, as not-a-branch: outcome 0, no BHT update, no count.
REQ-021 SHALL perform all comparisons at full XLEN, with signed ops using two's complement.
REQ-022 SHALL register results with 1-cycle latency: on the edge sampling RES_VALID=1, set OUT_VALID=1, BJ_SIG=outcome, and MISPREDICT=(outcome != RES_PRED_TAKEN); both MISPREDICT and BJ_SIG are forced 0 for not-a-branch.
REQ-023 SHALL, when RES_VALID=0 at the edge, set OUT_VALID=0, BJ_SIG=0 and MISPREDICT=0.
REQ-024 SHALL update the BHT only for conditional branches (not 1010): increment toward 11 if taken, decrement toward 00 if not taken; saturate at 11 and 00.
REQ-025 SHALL, when PRED_PC and RES_PC map to the same index in the same cycle, return the pre-update value on PRED_TAKEN; the update is visible from the next cycle.
REQ-026 SHALL increment BRANCH_COUNT on every valid branch or jump (including 1010), and increment MISPRED_COUNT when MISPREDICT is set.
REQ-027 SHALL saturate both counters at 32'hFFFFFFFF with no wrap.

Reset
REQ-028 SHALL, on a RESET-high edge, set every BHT entry to BHT_INIT, set OUT_VALID, BJ_SIG and MISPREDICT to 0, and clear both counters to 0.
REQ-029 SHALL ignore RES_VALID in any cycle where RESET is high: no update and no count; RESET takes priority over a resolve in the same cycle.
REQ-030 SHALL keep PRED_TAKEN combinational during reset, reflecting the table value before the reset edge.

Verification
REQ-031 Reset, then PRED_PC=0x40 -> PRED_TAKEN=0; all outputs and counters 0.
REQ-032 Resolve sequence 1 -> BLT, DATA1=0xFFFFFFFF, DATA2=1, RES_PRED_TAKEN=0 -> next cycle OUT_VALID=1, BJ_SIG=1, MISPREDICT=1.
REQ-033 Resolve sequence 2 -> same operands with BLTU -> BJ_SIG=0, MISPREDICT=0.
REQ-034 Three BEQ-taken resolves at RES_PC=0x40 (DATA1=DATA2=214) -> counter goes 01, 10, 11, 11 (saturated); PRED_TAKEN for 0x40 becomes 1 after the first update; PC 0x80 (same index at DEPTH=16) aliases.
REQ-035 JAL (1010) with RES_PRED_TAKEN=1 -> BJ_SIG=1, MISPREDICT=0, BHT unchanged, BRANCH_COUNT+1.
REQ-036 RESET and a RES_VALID BNE-taken in the same cycle -> BHT stays at BHT_INIT, counters stay 0, OUT_VALID=0.
